// File: rtl/lin_fit_pkg.sv
// Shared fixed-point constants and types for the line-fit blocks (regression and sweeper).
package lin_fit_pkg;

   localparam int A_FRAC = 3;
   localparam int B_FRAC = 10;
   localparam int A_W    = 18;
   localparam int B_W    = 25;
   localparam int ACC_W  = 38;

   localparam int X_MAX  = 1023;
   localparam int Y_MAX  = 767;
   localparam int X_W    = 11;
   localparam int Y_W    = 10;
   localparam int YF_W   = ACC_W - B_FRAC;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EMIT,
      S_DONE
   } sweep_state_t;

   // Brings the intercept onto the slope's binary point so acc = a*128 + b*x exactly.
   function automatic logic signed [ACC_W-1:0] align_intercept(input logic signed [A_W-1:0] a);
      return ACC_W'(a) <<< (B_FRAC - A_FRAC);
   endfunction

endpackage

// File: rtl/line_sweeper_y_round_clamp.sv
// Combinational rounding of the swept accumulator to an integer pixel row.
// Build option: define LINE_CLAMP_EN to saturate y_out to 0..Y_MAX instead of wrapping.
module y_round_clamp
   import lin_fit_pkg::*;
(
   input  logic signed [ACC_W-1:0] acc_in,
   output logic        [Y_W-1:0]   y_out,
   output logic                    in_range_out
);

   localparam logic signed [ACC_W-1:0] ROUND_HALF = ACC_W'(1 << (B_FRAC - 1));
   localparam logic signed [YF_W-1:0]  Y_MAX_F    = YF_W'(Y_MAX);

   logic signed [YF_W-1:0] y_full;
   logic                   below;
   logic                   above;

   assign y_full       = YF_W'((acc_in + ROUND_HALF) >>> B_FRAC);
   assign below        = y_full[YF_W-1];
   assign above        = !below && (y_full > Y_MAX_F);
   assign in_range_out = !below && !above;

`ifdef LINE_CLAMP_EN
   // NOTE: y_out gets a value on every path through this block, so no latch is inferred.
   always_comb begin
      y_out = y_full[Y_W-1:0];
      if (below)
         y_out = '0;
      else if (above)
         y_out = Y_W'(Y_MAX);
   end
`else
   assign y_out = y_full[Y_W-1:0];
`endif

endmodule

// File: rtl/line_sweeper.sv
// Sweeps x over 0..X_MAX for one latched (intercept, slope) pair and streams rounded (x, y) points.
// Build option: LINE_CLAMP_EN selects saturating y_out inside y_round_clamp.
module line_sweeper
   import lin_fit_pkg::*;
(
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic signed [A_W-1:0] a_in,
   input  logic signed [B_W-1:0] b_in,
   input  logic                  coef_valid_in,
   output logic                  coef_ready_out,
   input  logic                  abort_in,
   output logic [X_W-1:0]        x_out,
   output logic [Y_W-1:0]        y_out,
   output logic                  in_range_out,
   output logic                  valid_out,
   input  logic                  ready_in,
   output logic                  busy_out,
   output logic                  done_out
);

   sweep_state_t            state, state_next;
   logic                    load, step;
   logic [X_W-1:0]          x_q;
   logic signed [ACC_W-1:0] acc_q;
   logic signed [B_W-1:0]   b_q;
   logic                    in_range_raw;

   always_comb begin
      state_next = state;
      load       = 1'b0;
      step       = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (coef_valid_in) begin
               state_next = S_EMIT;
               load       = 1'b1;
            end
         end
         S_EMIT: begin
            if (ready_in) begin
               if (x_q == X_W'(X_MAX))
                  state_next = S_DONE;
               else
                  step = 1'b1;
            end
         end
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
      // Abort beats both a coefficient accept and a pending handshake.
      if (abort_in) begin
         state_next = S_IDLE;
         load       = 1'b0;
         step       = 1'b0;
      end
   end

   // NOTE: state and datapath registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state <= S_IDLE;
         x_q   <= '0;
         acc_q <= '0;
         b_q   <= '0;
      end else begin
         state <= state_next;
         if (load) begin
            x_q   <= '0;
            acc_q <= align_intercept(a_in);
            b_q   <= b_in;
         end else if (step) begin
            x_q   <= x_q + X_W'(1);
            acc_q <= acc_q + ACC_W'(b_q);
         end
      end
   end

   y_round_clamp u_y_round_clamp (
      .acc_in       (acc_q),
      .y_out        (y_out),
      .in_range_out (in_range_raw)
   );

   assign coef_ready_out = (state == S_IDLE);
   assign valid_out      = (state == S_EMIT);
   assign busy_out       = (state == S_EMIT);
   assign done_out       = (state == S_DONE);
   assign x_out          = x_q;
   // Only meaningful alongside a point, which also keeps it low out of reset.
   assign in_range_out   = in_range_raw && (state == S_EMIT);

endmodule

// File: tb/tb_line_sweeper.sv
// Self-checking bench for line_sweeper: a per-cycle reference model plus directed literal checks.
module tb_line_sweeper;

   logic               clk_in = 1'b0;
   logic               rst_in = 1'b1;
   logic signed [17:0] a_in = '0;
   logic signed [24:0] b_in = '0;
   logic               coef_valid_in = 1'b0;
   logic               coef_ready_out;
   logic               abort_in = 1'b0;
   logic [10:0]        x_out;
   logic [9:0]         y_out;
   logic               in_range_out;
   logic               valid_out;
   logic               ready_in = 1'b1;
   logic               busy_out;
   logic               done_out;

   int checks   = 0;
   int failures = 0;

   bit     chk_en   = 1'b0;
   bit     m_active = 1'b0;
   bit     m_done   = 1'b0;
   longint m_a      = 0;
   longint m_b      = 0;
   longint m_x      = 0;

   line_sweeper dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .a_in           (a_in),
      .b_in           (b_in),
      .coef_valid_in  (coef_valid_in),
      .coef_ready_out (coef_ready_out),
      .abort_in       (abort_in),
      .x_out          (x_out),
      .y_out          (y_out),
      .in_range_out   (in_range_out),
      .valid_out      (valid_out),
      .ready_in       (ready_in),
      .busy_out       (busy_out),
      .done_out       (done_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      failures++;
      $display("FAIL %s: timed out (t=%0t)", name, $time);
   endtask

   // y = round_half_up((a*128 + b*x) / 1024) as a true floor division.
   function automatic longint model_yfull(input longint a, input longint b, input longint x);
      longint num;
      num = a * 128 + b * x + 512;
      if (num >= 0)
         return num / 1024;
      return -((-num + 1023) / 1024);
   endfunction

   function automatic longint model_yout(input longint yf);
`ifdef LINE_CLAMP_EN
      if (yf < 0)   return 0;
      if (yf > 767) return 767;
      return yf;
`else
      return yf & 1023;
`endif
   endfunction

   function automatic longint model_inrange(input longint yf);
      return (yf >= 0 && yf <= 767) ? 1 : 0;
   endfunction

   // Compare process: check outputs mid-cycle, then advance the model by what the next edge will do.
   always @(negedge clk_in) begin
      if (chk_en) begin
         longint yf;
         check("valid_out",      valid_out,      m_active);
         check("busy_out",       busy_out,       m_active);
         check("done_out",       done_out,       m_done);
         check("coef_ready_out", coef_ready_out, (!m_active && !m_done) ? 1 : 0);
         if (m_active) begin
            yf = model_yfull(m_a, m_b, m_x);
            check("x_out",        x_out,        m_x);
            check("y_out",        y_out,        model_yout(yf));
            check("in_range_out", in_range_out, model_inrange(yf));
         end
         if (rst_in || abort_in) begin
            m_active = 1'b0;
            m_done   = 1'b0;
         end else if (m_active) begin
            if (ready_in) begin
               if (m_x == 1023) begin
                  m_active = 1'b0;
                  m_done   = 1'b1;
               end else begin
                  m_x++;
               end
            end
         end else if (m_done) begin
            m_done = 1'b0;
         end else if (coef_valid_in) begin
            m_active = 1'b1;
            m_x      = 0;
            m_a      = longint'(a_in);
            m_b      = longint'(b_in);
         end
      end
   end

   task automatic start_sweep(input longint a, input longint b);
      a_in          = 18'(a);
      b_in          = 25'(b);
      coef_valid_in = 1'b1;
      @(posedge clk_in); #1;
      coef_valid_in = 1'b0;
   endtask

   task automatic wait_x(input int t);
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk_in); #1;
         if (valid_out && x_out == 11'(t)) return;
      end
      timeout($sformatf("wait_x_%0d", t));
   endtask

   task automatic wait_done();
      for (int i = 0; i < 6000; i++) begin
         @(posedge clk_in); #1;
         if (done_out) begin
            @(posedge clk_in); #1;
            return;
         end
      end
      timeout("wait_done");
   endtask

   initial begin
      longint y_neg_exp;
      longint y_over_exp;
`ifdef LINE_CLAMP_EN
      y_neg_exp  = 0;
      y_over_exp = 767;
`else
      y_neg_exp  = 1023;
      y_over_exp = 768;
`endif

      // Pin the reference model against hand-computed points.
      check("model_y_0_512_3",      model_yfull(0, 512, 3), 2);
      check("model_y_800_m1024_101", model_yfull(800, -1024, 101), -1);
      check("model_out_neg",        model_yout(model_yfull(800, -1024, 101)), y_neg_exp);

      repeat (3) @(posedge clk_in);
      #1;
      check("rst_valid",      valid_out, 0);
      check("rst_busy",       busy_out, 0);
      check("rst_done",       done_out, 0);
      check("rst_x",          x_out, 0);
      check("rst_y",          y_out, 0);
      check("rst_in_range",   in_range_out, 0);
      check("rst_coef_ready", coef_ready_out, 1);
      rst_in = 1'b0;
      chk_en = 1'b1;

      // Flat line at y=100; done exactly one cycle after the last point.
      start_sweep(800, 0);
      check("flat_first_x", x_out, 0);
      check("flat_first_y", y_out, 100);
      wait_x(500);
      check("flat_y_500", y_out, 100);
      wait_x(1023);
      check("flat_in_range_1023", in_range_out, 1);
      @(posedge clk_in); #1;
      check("flat_done_pulse", done_out, 1);
      check("flat_valid_after", valid_out, 0);
      @(posedge clk_in); #1;
      check("flat_done_cleared", done_out, 0);
      check("flat_idle_ready", coef_ready_out, 1);

      // Half slope, rounding half up.
      start_sweep(0, 512);
      wait_x(3);
      check("half_y_3", y_out, 2);
      wait_x(4);
      check("half_y_4", y_out, 2);
      wait_x(1023);
      check("half_y_1023", y_out, 512);
      check("half_in_range_1023", in_range_out, 1);
      wait_done();

      // Descending line crossing below zero.
      start_sweep(800, -1024);
      wait_x(100);
      check("desc_y_100", y_out, 0);
      check("desc_in_range_100", in_range_out, 1);
      wait_x(101);
      check("desc_y_101", y_out, y_neg_exp);
      check("desc_in_range_101", in_range_out, 0);
      wait_done();

      // Unit slope crossing Y_MAX.
      start_sweep(0, 1024);
      wait_x(767);
      check("unit_y_767", y_out, 767);
      check("unit_in_range_767", in_range_out, 1);
      wait_x(768);
      check("unit_y_768", y_out, y_over_exp);
      check("unit_in_range_768", in_range_out, 0);
      wait_done();

      // Random back-pressure, with a coefficient pulse mid-sweep that must be ignored.
      start_sweep(-3000, 700);
      begin
         bit seen_done = 1'b0;
         for (int i = 0; i < 6000 && !seen_done; i++) begin
            ready_in = 1'($urandom_range(0, 1));
            if (i == 300) begin
               a_in          = 18'sd5;
               b_in          = 25'sd5;
               coef_valid_in = 1'b1;
            end else begin
               coef_valid_in = 1'b0;
            end
            @(posedge clk_in); #1;
            seen_done = done_out;
         end
         coef_valid_in = 1'b0;
         ready_in      = 1'b1;
         if (!seen_done) timeout("stall_sweep_done");
      end
      @(posedge clk_in); #1;

      // Abort mid-sweep, then a fresh pair from IDLE.
      start_sweep(100, 2000);
      wait_x(40);
      abort_in = 1'b1;
      @(posedge clk_in); #1;
      abort_in = 1'b0;
      check("abort_valid", valid_out, 0);
      check("abort_busy", busy_out, 0);
      check("abort_done", done_out, 0);
      check("abort_coef_ready", coef_ready_out, 1);
      start_sweep(0, 512);
      wait_x(5);
      check("post_abort_y_5", y_out, 3);

      // Reset mid-sweep returns every output to its reset value.
      wait_x(200);
      rst_in = 1'b1;
      @(posedge clk_in); #1;
      check("mrst_valid",      valid_out, 0);
      check("mrst_busy",       busy_out, 0);
      check("mrst_done",       done_out, 0);
      check("mrst_x",          x_out, 0);
      check("mrst_y",          y_out, 0);
      check("mrst_in_range",   in_range_out, 0);
      check("mrst_coef_ready", coef_ready_out, 1);
      rst_in = 1'b0;
      repeat (3) @(posedge clk_in);
      #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
